// File: rtl/centroid_ctrl_pkg.sv
// Shared widths and FSM state encodings for the centroid controller slice.
package centroid_ctrl_pkg;

    localparam int W_COORD_DEF = 11;
    localparam int W_ACC_DEF   = 32;

    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_ACC   = 2'd1;
    localparam logic [1:0] F_FLUSH = 2'd2;
    localparam logic [1:0] F_LATCH = 2'd3;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_DIV_X = 2'd1;
    localparam logic [1:0] D_DIV_Y = 2'd2;
    localparam logic [1:0] D_DONE  = 2'd3;

endpackage

// File: rtl/centroid_ctrl_pix_coord_cnt.sv
// Pixel coordinate tracker: de/v_sync edge detection and saturating x/y counters.
module pix_coord_cnt
    import centroid_ctrl_pkg::*;
#(
    parameter int W_COORD = W_COORD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de,
    input  logic               v_sync,
    output logic [W_COORD-1:0] x_cnt,
    output logic [W_COORD-1:0] y_cnt,
    output logic               frame_end
);

    localparam logic [W_COORD-1:0] CNT_MAX = '1;

    logic de_q;
    logic vs_q;
    logic de_fall;

    assign frame_end = v_sync & ~vs_q;
    assign de_fall   = de_q & ~de;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            de_q <= de;
            vs_q <= v_sync;

            if (de_fall)
                x_cnt <= '0;
            else if (de && x_cnt != CNT_MAX)
                x_cnt <= x_cnt + 1'b1;

            // A frame boundary outranks a line end arriving in the same cycle.
            if (frame_end)
                y_cnt <= '0;
            else if (de_fall && y_cnt != CNT_MAX)
                y_cnt <= y_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/centroid_ctrl.sv
// Frame controller for the centroid datapath: drives the accumulators and sequences the shared divider.
module centroid_ctrl
    import centroid_ctrl_pkg::*;
#(
    parameter int W_COORD = W_COORD_DEF,
    parameter int W_ACC   = W_ACC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de,
    input  logic               v_sync,
    input  logic               mask,
    output logic [W_COORD-1:0] x_pos,
    output logic [W_COORD-1:0] y_pos,
    output logic               acc_ce,
    output logic               acc_clr,
    input  logic [W_ACC-1:0]   sum_x,
    input  logic [W_ACC-1:0]   sum_y,
    input  logic [W_ACC-1:0]   cnt,
    output logic               div_start,
    output logic [W_ACC-1:0]   div_dividend,
    output logic [W_ACC-1:0]   div_divisor,
    input  logic               div_done,
    input  logic [W_ACC-1:0]   div_quotient,
    output logic [W_COORD-1:0] cent_x,
    output logic [W_COORD-1:0] cent_y,
    output logic               cent_valid,
    output logic               cent_empty,
    output logic               overrun
);

    logic [W_COORD-1:0] x_cnt;
    logic [W_COORD-1:0] y_cnt;
    logic               frame_end;
    logic               synced;
    logic [1:0]         f_state;
    logic               flush_cnt;
    logic [1:0]         d_state;
    logic [W_ACC-1:0]   sum_y_h;
    logic [W_COORD-1:0] qx;
    logic [W_COORD-1:0] qy;
    logic               job;
    logic               div_ack;
    logic               unused_q_hi;

    pix_coord_cnt #(.W_COORD(W_COORD)) u_coord (
        .clk       (clk),
        .rst       (rst),
        .de        (de),
        .v_sync    (v_sync),
        .x_cnt     (x_cnt),
        .y_cnt     (y_cnt),
        .frame_end (frame_end)
    );

    assign job         = (f_state == F_LATCH) && (d_state == D_IDLE);
    // A done arriving alongside our own start pulse belongs to no request of ours.
    assign div_ack     = div_done && !div_start;
    assign unused_q_hi = ^div_quotient[W_ACC-1:W_COORD];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_state   <= F_IDLE;
            flush_cnt <= 1'b0;
            synced    <= 1'b0;
            acc_ce    <= 1'b0;
            acc_clr   <= 1'b0;
            x_pos     <= '0;
            y_pos     <= '0;
            overrun   <= 1'b0;
        end else begin
            acc_ce  <= de & mask & synced;
            x_pos   <= x_cnt;
            y_pos   <= y_cnt;
            acc_clr <= 1'b0;
            overrun <= 1'b0;
            if (frame_end)
                synced <= 1'b1;

            case (f_state)
                F_IDLE: begin
                    if (frame_end) begin
                        acc_clr <= 1'b1;
                        f_state <= F_ACC;
                    end
                end
                F_ACC: begin
                    if (frame_end) begin
                        flush_cnt <= 1'b0;
                        f_state   <= F_FLUSH;
                    end
                end
                F_FLUSH: begin
                    // Two cycles let the final pixel travel through the registered ce and the accumulator.
                    flush_cnt <= 1'b1;
                    if (flush_cnt)
                        f_state <= F_LATCH;
                end
                default: begin
                    acc_clr <= 1'b1;
                    overrun <= (d_state != D_IDLE);
                    f_state <= F_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state      <= D_IDLE;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            sum_y_h      <= '0;
            qx           <= '0;
            qy           <= '0;
            cent_x       <= '0;
            cent_y       <= '0;
            cent_valid   <= 1'b0;
            cent_empty   <= 1'b0;
        end else begin
            div_start  <= 1'b0;
            cent_valid <= 1'b0;

            case (d_state)
                D_IDLE: begin
                    if (job) begin
                        sum_y_h <= sum_y;
                        if (cnt == '0) begin
                            cent_empty <= 1'b1;
                            cent_valid <= 1'b1;
                        end else begin
                            // The divider operand registers double as the sum_x/cnt holding registers.
                            div_start    <= 1'b1;
                            div_dividend <= sum_x;
                            div_divisor  <= cnt;
                            d_state      <= D_DIV_X;
                        end
                    end
                end
                D_DIV_X: begin
                    if (div_ack) begin
                        qx           <= div_quotient[W_COORD-1:0];
                        div_start    <= 1'b1;
                        div_dividend <= sum_y_h;
                        d_state      <= D_DIV_Y;
                    end
                end
                D_DIV_Y: begin
                    if (div_ack) begin
                        qy      <= div_quotient[W_COORD-1:0];
                        d_state <= D_DONE;
                    end
                end
                default: begin
                    cent_x     <= qx;
                    cent_y     <= qy;
                    cent_empty <= 1'b0;
                    cent_valid <= 1'b1;
                    d_state    <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_ctrl.sv
// Self-checking bench for centroid_ctrl with accumulator/divider models and a per-frame centroid reference.
module tb_centroid_ctrl;

    localparam int WC = 11;
    localparam int WA = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          de = 1'b0;
    logic          v_sync = 1'b0;
    logic          mask = 1'b0;
    logic [WC-1:0] x_pos, y_pos, cent_x, cent_y;
    logic          acc_ce, acc_clr, div_start, div_done, cent_valid, cent_empty, overrun;
    logic [WA-1:0] sum_x, sum_y, cnt, div_dividend, div_divisor, div_quotient;

    centroid_ctrl #(.W_COORD(WC), .W_ACC(WA)) dut (
        .clk          (clk),
        .rst          (rst),
        .de           (de),
        .v_sync       (v_sync),
        .mask         (mask),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .acc_ce       (acc_ce),
        .acc_clr      (acc_clr),
        .sum_x        (sum_x),
        .sum_y        (sum_y),
        .cnt          (cnt),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .cent_x       (cent_x),
        .cent_y       (cent_y),
        .cent_valid   (cent_valid),
        .cent_empty   (cent_empty),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Three accumulators sharing rst; the synchronous clear beats ce.
    always @(posedge clk or posedge rst) begin
        if (rst || acc_clr) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (acc_ce) begin
            sum_x <= sum_x + WA'(x_pos);
            sum_y <= sum_y + WA'(y_pos);
            cnt   <= cnt + 1;
        end
    end

    // Divider with programmable latency and optional stray done pulses.
    int            div_lat = 5;
    logic          spur_idle = 1'b0;
    logic          spur_coinc = 1'b0;
    logic          done_r, dbusy;
    logic [WA-1:0] q_r, dvd, dvs;
    int            dcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dbusy  <= 1'b0;
            done_r <= 1'b0;
            dcnt   <= 0;
            q_r    <= '0;
            dvd    <= '0;
            dvs    <= '0;
        end else begin
            done_r <= 1'b0;
            if (div_start) begin
                dbusy <= 1'b1;
                dcnt  <= div_lat;
                dvd   <= div_dividend;
                dvs   <= div_divisor;
            end else if (dbusy) begin
                if (dcnt <= 1) begin
                    dbusy  <= 1'b0;
                    done_r <= 1'b1;
                    q_r    <= dvd / dvs;
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
        end
    end

    assign div_done     = done_r | spur_idle | (spur_coinc & div_start);
    assign div_quotient = done_r ? q_r : 32'h0000_05a5;

    // Reference model: expected results and divider jobs per completed frame.
    typedef struct { bit empty; int cx; int cy; } res_t;
    typedef struct { logic [WA-1:0] dvd; logic [WA-1:0] dvs; } job_t;
    res_t exp_q[$];
    job_t job_q[$];
    int   last_cx = 0, last_cy = 0;
    int   n_ovr = 0, exp_ovr = 0, n_dstart = 0;
    longint fsx = 0, fsy = 0, fcnt = 0;
    bit   synced_m = 0, drop_next = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (div_start) begin
                n_dstart++;
                if (job_q.size() == 0) begin
                    check("unexp_div_start", div_start, 0);
                end else begin
                    job_t j;
                    j = job_q.pop_front();
                    check("div_dividend", div_dividend, j.dvd);
                    check("div_divisor", div_divisor, j.dvs);
                end
            end
            if (cent_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexp_cent_valid", cent_valid, 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("cent_empty", cent_empty, r.empty);
                    if (r.empty) begin
                        check("cent_x_hold", cent_x, last_cx);
                        check("cent_y_hold", cent_y, last_cy);
                    end else begin
                        check("cent_x", cent_x, r.cx);
                        check("cent_y", cent_y, r.cy);
                        last_cx = r.cx;
                        last_cy = r.cy;
                    end
                end
            end
            if (overrun) n_ovr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {acc_ce, acc_clr, div_start, cent_valid, cent_empty, overrun}, 0);
        check({tag, "_pos"}, {x_pos, y_pos}, 0);
        check({tag, "_cent"}, {cent_x, cent_y}, 0);
        check({tag, "_div"}, {div_dividend, div_divisor}, 0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        de     = 1'b0;
        mask   = 1'b0;
        v_sync = 1'b0;
        #1;
        check_reset_outputs("rst");
        exp_q.delete();
        job_q.delete();
        synced_m = 0;
        drop_next = 0;
        fsx = 0; fsy = 0; fcnt = 0;
        last_cx = 0; last_cy = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) tick();
    endtask

    function automatic bit mask_at(input int mode, input int x, input int y);
        case (mode)
            1:       return (x == 2 && y == 1);
            2:       return (x == 0 && y == 0) || (x == 3 && y == 2);
            3:       return 1'b0;
            default: return ($urandom_range(2) == 0);
        endcase
    endfunction

    // rst_at >= 0 aborts the frame with a reset at that pixel index.
    task automatic send_frame(input int w, input int h, input int mode, input int rst_at);
        int pix = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (pix == rst_at) begin
                    do_reset();
                    return;
                end
                de   = 1'b1;
                mask = mask_at(mode, x, y);
                if (mask) begin
                    fsx += x;
                    fsy += y;
                    fcnt++;
                end
                tick();
                pix++;
            end
            de   = 1'b0;
            mask = 1'b0;
            if (y != h - 1) repeat (3) tick();
        end
    endtask

    task automatic sync();
        res_t r;
        job_t j;
        v_sync = 1'b1;
        if (synced_m) begin
            if (drop_next) begin
                exp_ovr++;
                drop_next = 0;
            end else begin
                r.empty = (fcnt == 0);
                r.cx = (fcnt == 0) ? 0 : int'(fsx / fcnt);
                r.cy = (fcnt == 0) ? 0 : int'(fsy / fcnt);
                exp_q.push_back(r);
                if (fcnt != 0) begin
                    j.dvd = WA'(fsx); j.dvs = WA'(fcnt); job_q.push_back(j);
                    j.dvd = WA'(fsy); job_q.push_back(j);
                end
            end
        end
        synced_m = 1;
        fsx = 0; fsy = 0; fcnt = 0;
        repeat (2) tick();
        v_sync = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || job_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size() + job_q.size(), 0);
    endtask

    initial begin
        int target;
        int n;
        #1;
        check_reset_outputs("init");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();

        // Single object pixel at (2,1) after a sync frame.
        sync();
        send_frame(4, 3, 1, -1);
        sync();
        wait_drain();
        check("t1_cent_x", cent_x, 2);
        check("t1_cent_y", cent_y, 1);

        // Two pixels, floored average.
        send_frame(4, 3, 2, -1);
        sync();
        wait_drain();
        check("t2_cent_x", cent_x, 1);
        check("t2_cent_y", cent_y, 1);

        // Empty frame keeps the previous centroid.
        send_frame(4, 3, 3, -1);
        sync();
        wait_drain();
        check("t3_empty", cent_empty, 1);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            send_frame($urandom_range(16, 5), $urandom_range(6, 2), 4, -1);
            sync();
            wait_drain();
        end

        // Slow divider: second frame ends while the first is still dividing.
        div_lat = 100;
        send_frame(4, 3, 2, -1);
        sync();
        drop_next = 1;
        send_frame(4, 3, 4, -1);
        sync();
        wait_drain();
        check("overrun_count", n_ovr, exp_ovr);
        div_lat = 5;
        send_frame(4, 3, 1, -1);
        sync();
        wait_drain();

        // Reset in the middle of accumulation.
        send_frame(6, 4, 4, 10);
        send_frame(4, 3, 4, -1);
        sync();
        send_frame(8, 4, 4, -1);
        sync();
        wait_drain();

        // Reset while the y division is outstanding.
        div_lat = 100;
        send_frame(4, 3, 2, -1);
        target = n_dstart + 2;
        sync();
        n = 0;
        while (n_dstart < target && n < 500) begin
            tick();
            n++;
        end
        check("reached_div_y", n_dstart, target);
        repeat (10) tick();
        do_reset();
        div_lat = 5;
        repeat (50) tick();
        send_frame(4, 3, 4, -1);
        sync();
        send_frame(4, 3, 2, -1);
        sync();
        wait_drain();

        // Stray done while idle, then done coincident with each start.
        spur_idle = 1'b1;
        tick();
        spur_idle = 1'b0;
        repeat (5) tick();
        spur_coinc = 1'b1;
        send_frame(5, 4, 2, -1);
        sync();
        wait_drain();
        spur_coinc = 1'b0;
        check("t6_cent_x", cent_x, 1);
        check("t6_cent_y", cent_y, 1);

        check("overrun_total", n_ovr, exp_ovr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/centroid_ctrl.md
Name: centroid_ctrl

Overview:
- Frame-level controller for the centroid datapath.
- Tracks pixel coordinates from the video timing inputs and drives the three accumulator instances: sum_x, sum_y and pixel count. The count accumulator has its A input tied to 1.
- At end of frame it latches the sums, clears the accumulators, and sequences one shared 32-bit divider twice (x, then y) to produce the centroid.

Parameters:
W_COORD, 11, coordinate width; must match accumulator A width.
W_ACC, 32, accumulator and divider width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
de  in  1  data enable, high during active pixels
v_sync  in  1  vertical sync; rising edge = end of frame
mask  in  1  binarised pixel, 1 = object
x_pos  out  W_COORD  A input of sum_x accumulator
y_pos  out  W_COORD  A input of sum_y accumulator
acc_ce  out  1  ce for all three accumulators
acc_clr  out  1  one-cycle synchronous clear to accumulators (ORed into their rst)
sum_x  in  W_ACC  sum_x accumulator Y
sum_y  in  W_ACC  sum_y accumulator Y
cnt  in  W_ACC  count accumulator Y
div_start  out  1  one-cycle start pulse to shared divider
div_dividend  out  W_ACC  dividend, held stable while dividing
div_divisor  out  W_ACC  divisor, held stable while dividing
div_done  in  1  one-cycle quotient-valid pulse
div_quotient  in  W_ACC  quotient
cent_x  out  W_COORD  centroid x
cent_y  out  W_COORD  centroid y
cent_valid  out  1  one-cycle pulse when cent_x/cent_y/cent_empty update
cent_empty  out  1  last frame had cnt = 0
overrun  out  1  one-cycle pulse when a frame result is dropped

Behaviour:
- Reset (async): every output is 0, every counter is 0, synced=0, both FSMs go to IDLE.
- Coordinate counters:
  - x_cnt increments on each de=1 cycle and resets to 0 on the falling edge of de.
  - The same de falling edge increments y_cnt.
  - y_cnt resets on the v_sync rising edge.
  - Both counters saturate at 2^W_COORD-1; they do not wrap.
- Accumulate pipeline:
  - acc_ce, x_pos and y_pos are registered together: acc_ce = de & mask & synced from the previous cycle.
  - Accumulator Y therefore reflects a pixel 2 cycles after it is presented.
- synced:
  - Set at the first v_sync rising edge after reset.
  - Until then acc_ce=0, so a partial first frame is discarded.
- Frame FSM: IDLE -> ACC -> FLUSH -> LATCH -> ACC.
  - IDLE: wait for a v_sync edge. On the edge, assert acc_clr and go to ACC.
  - ACC: on a v_sync rising edge go to FLUSH.
  - FLUSH: lasts 2 cycles so the last pixel lands in the accumulators.
  - LATCH: capture sum_x/sum_y/cnt into holding registers, assert acc_clr for 1 cycle, raise the job request, return to ACC.
  - acc_clr has priority over acc_ce in the same cycle; the clear wins.
- Divider FSM: IDLE -> DIV_X -> DIV_Y -> DONE -> IDLE.
  - On a job with cnt_h=0: skip the divider. cent_empty=1, cent_valid pulses, cent_x/cent_y hold their previous values.
  - On a job with cnt_h!=0, DIV_X: div_start pulses once with dividend=sum_x_h, divisor=cnt_h, then waits for div_done.
  - DIV_Y: same with dividend=sum_y_h.
  - DONE: cent_x and cent_y take quotient[W_COORD-1:0] (truncation, floor); cent_empty=0; cent_valid pulses one cycle.
  - div_done is ignored outside DIV_X/DIV_Y, including a div_done in the same cycle as div_start.
- Overrun: a LATCH while the divider FSM is not IDLE:
  - The new sums are dropped and overrun pulses.
  - The accumulators are still cleared.
  - The frame in progress completes normally.
- The accumulate path never stalls on the divider.
- Reset mid-operation:
  - Immediate return to IDLE; no div_start is issued afterwards until a new job.
  - synced returns to 0.
  - The accumulators share rst and therefore clear as well.

Decomposition:
- Shared package holds:
  - W_COORD and W_ACC defaults.
  - Frame FSM state encoding: IDLE, ACC, FLUSH, LATCH.
  - Divider FSM state encoding: IDLE, DIV_X, DIV_Y, DONE.
- Sub-module pix_coord_cnt: de/v_sync edge detection plus saturating x/y counters; outputs coordinates and a frame_end pulse.
- The two FSMs and the holding registers stay in centroid_ctrl.

Test Plan:
- Frame 4x3 (de high 4 cycles per line, 3 lines), mask only at (2,1), preceded by a sync frame -> div_start twice with dividends 2 then 1, divisor 1; cent_x=2, cent_y=1, cent_valid one pulse, cent_empty=0.
- mask at (0,0) and (3,2) -> sums 3/2, cnt 2; cent_x=1, cent_y=1 (floor).
- All-zero mask frame -> no div_start; cent_valid pulses; cent_empty=1; cent_x/cent_y unchanged from the previous frame.
- Divider model delays div_done by 100 cycles; a second frame ends during DIV_X -> overrun pulses once; the first frame's result is still delivered; the third frame's result is correct (accumulators were cleared).
- rst asserted mid-ACC and again during DIV_Y -> all outputs 0 immediately; no cent_valid; the next frame is discarded until the first v_sync edge, then results are correct.
- Spurious div_done in IDLE, and div_done coincident with div_start -> ignored; the FSM still waits for the proper done; the final centroid is correct.
